// File: rtl/sap1_program_loader_pkg.sv
// Shared definitions for the SAP-1 program loader: frame sync byte,
// default RAM geometry and the loader state encoding.
package sap1_program_loader_pkg;

    localparam int unsigned   ADDR_W_DEF = 4;
    localparam int unsigned   DATA_W_DEF = 8;
    localparam logic [7:0]    SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/sap1_program_loader_if.sv
// Valid/ready byte stream feeding the program loader (e.g. from a UART receiver).
interface sap1_program_loader_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sap1_program_loader.sv
// Writes a framed byte stream (SYNC, LEN, data, CSUM) into SAP-1 program RAM and
// holds the CPU in reset until a frame with a matching checksum has been loaded.
module sap1_program_loader
    import sap1_program_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W = ADDR_W_DEF,
    parameter int unsigned       DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SYNC   = SYNC_BYTE
) (
    input  logic                        clk,
    input  logic                        reset,
    sap1_program_loader_if.slave        in_bus,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic                        cpu_reset,
    input  logic                        cpu_halted,
    output logic                        loading,
    output logic                        error,
    output logic                        done
);

    localparam logic [DATA_W-1:0] DEPTH_MAX = DATA_W'(2 ** ADDR_W);

    state_t            state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic [DATA_W-1:0] sum;
    logic              accept;

    assign in_bus.in_ready = ~reset;
    assign accept          = in_bus.in_valid & in_bus.in_ready;
    assign count_next      = count + (ADDR_W + 1)'(1);
    assign done            = ~cpu_reset & cpu_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cpu_reset <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            error     <= 1'b0;
            loading   <= 1'b0;
            len       <= '0;
            count     <= '0;
            sum       <= '0;
        end else begin
            ram_we <= 1'b0;
            if (accept) begin
                unique case (state)
                    ST_IDLE, ST_RUN, ST_ERR: begin
                        // Only SYNC (re)starts a load; in LEN/DATA/CSUM it is plain payload.
                        if (in_bus.in_data == SYNC) begin
                            state     <= ST_LEN;
                            cpu_reset <= 1'b1;
                            error     <= 1'b0;
                            loading   <= 1'b1;
                        end
                    end
                    ST_LEN: begin
                        if (in_bus.in_data == '0 || in_bus.in_data > DEPTH_MAX) begin
                            state   <= ST_ERR;
                            error   <= 1'b1;
                            loading <= 1'b0;
                        end else begin
                            len   <= in_bus.in_data[ADDR_W:0];
                            count <= '0;
                            sum   <= '0;
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        ram_we    <= 1'b1;
                        ram_addr  <= count[ADDR_W-1:0];
                        ram_wdata <= in_bus.in_data;
                        count     <= count_next;
                        sum       <= sum + in_bus.in_data;
                        if (count_next == len) begin
                            state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        loading <= 1'b0;
                        if (in_bus.in_data == sum) begin
                            state     <= ST_RUN;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sap1_program_loader.sv
// Directed bench for sap1_program_loader: frame acceptance, checksum wrap and
// rejection, length limits, gapped loading, mid-frame reset and resync from RUN.
module tb_sap1_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_halted;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_reset;
    logic       loading;
    logic       error;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16];
    int         we_count = 0;
    int         we_mark;
    logic [7:0] prog [16];
    logic [7:0] csum;

    always #5 clk = ~clk;

    sap1_program_loader_if #(.DATA_W(8)) bus ();

    sap1_program_loader #(
        .ADDR_W (4),
        .DATA_W (8),
        .SYNC   (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_bus     (bus.slave),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .cpu_reset  (cpu_reset),
        .cpu_halted (cpu_halted),
        .loading    (loading),
        .error      (error),
        .done       (done)
    );

    // RAM image as seen through the write port
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_count      <= we_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        cpu_halted   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_ram_we",    ram_we,    0);
        chk("rst_ram_addr",  ram_addr,  0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_error",     error,     0);
        chk("rst_loading",   loading,   0);
        chk("rst_in_ready",  bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("in_ready_run", bus.in_ready, 1);
        chk("done_held",    done,         0);

        // 1: basic three-byte frame
        send(8'h33);
        chk("idle_discard", loading, 0);
        send(8'hA5);
        chk("t1_loading", loading, 1);
        send(8'h03);
        send(8'h10);
        chk("t1_we0",   ram_we,    1);
        chk("t1_addr0", ram_addr,  0);
        chk("t1_data0", ram_wdata, 8'h10);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_gap_we",      ram_we,  0);
        chk("t1_gap_loading", loading, 1);
        send(8'h20);
        chk("t1_addr1", ram_addr,  1);
        chk("t1_data1", ram_wdata, 8'h20);
        send(8'h30);
        chk("t1_addr2", ram_addr,  2);
        chk("t1_data2", ram_wdata, 8'h30);
        chk("t1_cpu_held", cpu_reset, 1);
        send(8'h60);
        chk("t1_cpu_run",  cpu_reset, 0);
        chk("t1_error",    error,     0);
        chk("t1_csum_we",  ram_we,    0);
        chk("t1_loading0", loading,   0);
        chk("t1_we_count", we_count,  3);

        // 2: FF+02 wraps to 01 -> accepted; CSUM 05 -> rejected
        send(8'h11);
        chk("run_ignore", cpu_reset, 0);
        send(8'hA5);
        chk("t2_resync_cpu", cpu_reset, 1);
        send(8'h02);
        send(8'hFF);
        send(8'h02);
        send(8'h01);
        chk("t2_wrap_ok", cpu_reset, 0);
        chk("t2_wrap_err", error, 0);
        send(8'hA5);
        send(8'h02);
        send(8'hFF);
        send(8'h02);
        send(8'h05);
        chk("t2_bad_err", error,     1);
        chk("t2_bad_cpu", cpu_reset, 1);

        // 3: length limits
        we_mark = we_count;
        send(8'hA5);
        chk("t3_err_clear", error, 0);
        send(8'h00);
        chk("t3_len0_err", error, 1);
        send(8'h44);
        chk("t3_err_ignore", error, 1);
        send(8'hA5);
        send(8'h11);
        chk("t3_len17_err", error, 1);
        repeat (2) @(posedge clk);
        chk("t3_no_we", we_count, we_mark);
        send(8'hA5);
        send(8'h01);
        send(8'h07);
        send(8'h07);
        chk("t3_ok_err", error,     0);
        chk("t3_ok_cpu", cpu_reset, 0);
        @(posedge clk);
        #1;
        chk("t3_mem0", mem[0], 8'h07);
        chk("t3_mem1_kept", mem[1], 8'h02);

        // 4: full 16-byte program with random gaps
        prog = '{8'h1E, 8'h2F, 8'hE0, 8'h3F, 8'h1F, 8'h2E, 8'hE0, 8'h3E,
                 8'h1F, 8'h3E, 8'h64, 8'hF0, 8'h00, 8'h00, 8'h01, 8'h00};
        csum = 8'h00;
        for (int i = 0; i < 16; i++) csum = csum + prog[i];
        send(8'hA5);
        send(8'h10);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(prog[i]);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send(csum);
        chk("t4_cpu_run", cpu_reset, 0);
        chk("t4_error",   error,     0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) chk($sformatf("t4_mem%0d", i), mem[i], prog[i]);
        chk("t4_done_lo", done, 0);
        cpu_halted = 1'b1;
        #1;
        chk("t4_done_hi", done, 1);
        cpu_halted = 1'b0;

        // 5: reset after 2 of 4 data bytes
        we_mark = we_count;
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_cpu_reset", cpu_reset, 1);
        chk("t5_ram_we",    ram_we,    0);
        chk("t5_ram_addr",  ram_addr,  0);
        chk("t5_ram_wdata", ram_wdata, 0);
        chk("t5_loading",   loading,   0);
        chk("t5_error",     error,     0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h03);
        chk("t5_idle_we", ram_we, 0);
        send(8'h04);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_we_count", we_count, we_mark + 2);
        chk("t5_mem0", mem[0], 8'h01);
        chk("t5_mem1", mem[1], 8'h02);
        chk("t5_mem2_kept", mem[2], 8'hE0);

        // 6: SYNC byte as payload inside DATA
        send(8'hA5);
        send(8'h02);
        send(8'hA5);
        chk("t6_payload_we",   ram_we,    1);
        chk("t6_payload_data", ram_wdata, 8'hA5);
        send(8'h01);
        send(8'hA6);
        chk("t6_cpu_run", cpu_reset, 0);
        send(8'hA5);
        chk("t6_resync_cpu", cpu_reset, 1);
        chk("t6_resync_loading", loading, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
